pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: funct  in  3  funct3 of current instruction.
REQ-005 SHALL have ports: is_branch / is_jal / is_jalr  in  1 each  instruction class flags.
REQ-006 SHALL have ports: BrEq, BrLT  in  1 each  branch comparator results.
REQ-007 SHALL have ports: imm  in  32  sign-extended immediate; rs1  in  32  JALR base.
REQ-008 SHALL have ports: stall  in  1  hold current instruction in EXEC.
REQ-009 SHALL have ports: imem_ready  in  1  instruction memory accepts/returns fetch.
REQ-010 SHALL have ports: imem_req  out  1  fetch request; pc  out  32  current PC; pc_plus4  out  32  pc+4 (link value).
REQ-011 SHALL have ports: PCSel  out  1  1 = redirect taken; misalign  out  1  sticky target-misaligned trap.
REQ-012 SHALL have ports: br_cnt, taken_cnt  out  32 each  statistics (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, EXEC, TRAP.
REQ-014 SHALL go IDLE->FETCH unconditionally one cycle after reset release.
REQ-015 SHALL drive imem_req=1 only in FETCH; FETCH->EXEC when imem_ready=1, else remain in FETCH.
REQ-016 SHALL hold pc and remain in EXEC while stall=1; PCSel evaluated regardless of stall.
REQ-017 SHALL decide branch taken: 000 BrEq; 001 ~BrEq; 100/110 BrLT; 101/111 ~BrLT; 010/011 never taken.
REQ-018 SHALL drive PCSel combinationally in EXEC: is_jalr | is_jal | (is_branch & taken); PCSel=0 in all other states.
REQ-019 SHALL prioritise flags jalr > jal > branch when several are asserted.
REQ-020 SHALL compute target: jalr -> (rs1+imm) & ~32'h1; jal/branch -> pc+imm; all sums modulo 2^32 (wrap, no overflow flag).
REQ-021 SHALL, in EXEC with stall=0: if PCSel=1 and target[1:0]!=0 -> TRAP, pc unchanged; else pc<=PCSel?target:pc+4, -> FETCH.
REQ-022 SHALL, in TRAP, hold pc, keep misalign=1, imem_req=0, exit only on rst.
REQ-023 SHALL drive pc_plus4 = pc+4 combinationally (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 SHALL not check alignment of not-taken fall-through.

Reset
REQ-025 SHALL on rst=1 at a clock edge, from any state including mid-FETCH or TRAP: state=IDLE, pc=RESET_PC, misalign=0, counters=0; rst wins over all other inputs.
REQ-026 SHALL, during and after reset until FETCH, drive imem_req=0 and PCSel=0.

Configuration
REQ-027 SHALL, with PC_CTRL_STATS_EN defined, increment br_cnt on every EXEC->FETCH/TRAP retirement with is_branch=1 and taken_cnt when that branch is taken; both wrap at 2^32.
REQ-028 SHALL, without PC_CTRL_STATS_EN, keep the ports and tie br_cnt and taken_cnt to 0 with no counter logic.

Structure
REQ-029 SHALL place funct3 branch encodings, state encodings and default RESET_PC in shared package pc_ctrl_pkg.
REQ-030 SHALL isolate the REQ-017 taken decision in combinational sub-module br_decide.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles, RESET_PC=32'h100 -> pc=32'h100, imem_req=0, IDLE then FETCH with imem_req=1.
REQ-032 SHALL cover BEQ: pc=32'h100, funct=000, BrEq=1, imm=32'h20 -> PCSel=1, next pc=32'h120; BrEq=0 -> pc=32'h104.
REQ-033 SHALL cover BGEU and stall: funct=111, BrLT=0, imm=-8, stall=1 for 3 cycles -> pc held 3 cycles, then pc-8.
REQ-034 SHALL cover JALR: rs1=32'h2001, imm=32'h3 -> target 32'h2004, pc_plus4 = old pc+4.
REQ-035 SHALL cover misaligned trap: JAL imm=32'h2 from pc=32'h100 -> TRAP, misalign=1, pc=32'h100, held until rst clears.
REQ-036 SHALL cover fetch wait and wrap: imem_ready=0 for 5 cycles -> stay FETCH; pc=32'hFFFF_FFFC not-taken -> pc=0; with PC_CTRL_STATS_EN, 3 branches/2 taken -> br_cnt=3, taken_cnt=2.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: FSM state encoding, funct3 branch encodings and default reset PC
// shared by pc_ctrl and br_decide.
package pc_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
   localparam logic [2:0] F_BEQ  = 3'b000;
   localparam logic [2:0] F_BNE  = 3'b001;
   localparam logic [2:0] F_BLT  = 3'b100;
   localparam logic [2:0] F_BGE  = 3'b101;
   localparam logic [2:0] F_BLTU = 3'b110;
   localparam logic [2:0] F_BGEU = 3'b111;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_ctrl_br_decide.sv
// br_decide: combinational branch-taken decision from funct3 and comparator flags;
// unsigned and signed variants share BrLT, reserved encodings are never taken.
module br_decide
   import pc_ctrl_pkg::*;
(
   input  logic [2:0] funct,
   input  logic       BrEq,
   input  logic       BrLT,
   output logic       taken
);
   assign taken = funct == F_BEQ ? BrEq :
                  funct == F_BNE ? ~BrEq :
                  (funct == F_BLT || funct == F_BLTU) ? BrLT :
                  (funct == F_BGE || funct == F_BGEU) ? ~BrLT : 1'b0;
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: IDLE/FETCH/EXEC/TRAP program-counter sequencer with branch/jump redirect
// and sticky misaligned-target trap; define PC_CTRL_STATS_EN for branch statistics counters.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  funct,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        BrEq,
   input  logic        BrLT,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        stall,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        PCSel,
   output logic        misalign,
   output logic [31:0] br_cnt,
   output logic [31:0] taken_cnt
);
   state_t state, nextState;
   logic [31:0] nextPc, target, jalrSum;
   logic taken, retire;
   br_decide uBrDecide (.funct(funct), .BrEq(BrEq), .BrLT(BrLT), .taken(taken));
   assign jalrSum  = rs1 + imm;
   assign target   = is_jalr ? {jalrSum[31:1], 1'b0} : pc + imm;
   assign pc_plus4 = pc + 32'd4;
   assign PCSel    = state == EXEC && (is_jalr || is_jal || (is_branch && taken));
   assign imem_req = state == FETCH;
   assign misalign = state == TRAP;
   assign retire   = state == EXEC && !stall;
   always_comb begin
      nextState = state;
      nextPc    = pc;
      case (state)
         IDLE:  nextState = FETCH;
         FETCH: nextState = imem_ready ? EXEC : FETCH;
         EXEC: begin
            if (!stall) begin
               nextState = (PCSel && target[1:0] != 2'b00) ? TRAP : FETCH;
               nextPc    = (PCSel && target[1:0] != 2'b00) ? pc : (PCSel ? target : pc_plus4);
            end
         end
         default: nextState = TRAP;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= nextState;
         pc    <= nextPc;
      end
   end
`ifdef PC_CTRL_STATS_EN
   logic [31:0] brCnt, takenCnt;
   logic isBr;
   // a jump flag outranks is_branch, so only pure branches are counted
   assign isBr = is_branch && !is_jal && !is_jalr;
   always_ff @(posedge clk) begin
      if (rst) begin
         brCnt    <= '0;
         takenCnt <= '0;
      end else if (retire && isBr) begin
         brCnt    <= brCnt + 32'd1;
         takenCnt <= taken ? takenCnt + 32'd1 : takenCnt;
      end
   end
   assign br_cnt    = brCnt;
   assign taken_cnt = takenCnt;
`else
   assign br_cnt    = '0;
   assign taken_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: table-driven directed checks of pc_ctrl plus hand sequences for
// stall, fetch wait, misaligned trap, reset mid-fetch and statistics.
module tb_pc_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] funct = '0;
   logic is_branch = 0, is_jal = 0, is_jalr = 0, BrEq = 0, BrLT = 0, stall = 0, imem_ready = 0;
   logic [31:0] imm = '0, rs1 = '0;
   logic imem_req, PCSel, misalign;
   logic [31:0] pc, pc_plus4, br_cnt, taken_cnt;
   int total = 0, bad = 0;

   typedef struct {
      logic        rstFirst;
      logic [2:0]  funct;
      logic        isBranch, isJal, isJalr, brEq, brLt;
      logic [31:0] imm, rs1;
      logic        expSel;
      logic [31:0] expPc, expNext;
   } vec_t;
   vec_t vecs[16];

   pc_ctrl #(.RESET_PC(32'h100)) dut (
      .clk(clk), .rst(rst), .funct(funct), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .BrEq(BrEq), .BrLT(BrLT), .imm(imm), .rs1(rs1), .stall(stall),
      .imem_ready(imem_ready), .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
      .PCSel(PCSel), .misalign(misalign), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearIn();
      funct = '0; is_branch = 0; is_jal = 0; is_jalr = 0; BrEq = 0; BrLT = 0;
      stall = 0; imem_ready = 0; imm = '0; rs1 = '0;
   endtask

   task automatic doReset();
      rst = 1;
      clearIn();
      tick();
      tick();
      chk("rst_pc", pc, 32'h100);
      chk("rst_req", {31'd0, imem_req}, 0);
      chk("rst_sel", {31'd0, PCSel}, 0);
      chk("rst_mis", {31'd0, misalign}, 0);
      chk("rst_br", br_cnt, 0);
      chk("rst_tk", taken_cnt, 0);
      rst = 0;
      chk("idle_req", {31'd0, imem_req}, 0);
      tick();
      chk("fetch_req", {31'd0, imem_req}, 1);
      chk("fetch_pc", pc, 32'h100);
   endtask

   task automatic apply(input vec_t v);
      funct = v.funct; is_branch = v.isBranch; is_jal = v.isJal; is_jalr = v.isJalr;
      BrEq = v.brEq; BrLT = v.brLt; imm = v.imm; rs1 = v.rs1;
   endtask

   task automatic runVec(input vec_t v, input string tag);
      if (v.rstFirst) doReset();
      apply(v);
      imem_ready = 1;
      tick();
      imem_ready = 0;
      chk({tag, "_exec_req"}, {31'd0, imem_req}, 0);
      chk({tag, "_sel"}, {31'd0, PCSel}, {31'd0, v.expSel});
      chk({tag, "_pc"}, pc, v.expPc);
      chk({tag, "_plus4"}, pc_plus4, v.expPc + 32'd4);
      tick();
      chk({tag, "_next"}, pc, v.expNext);
      chk({tag, "_req"}, {31'd0, imem_req}, 1);
      chk({tag, "_mis"}, {31'd0, misalign}, 0);
   endtask

   initial begin
      vec_t v;
      logic [31:0] expBr, expTk;
      //           rst   funct   br    jal   jalr  eq    lt    imm            rs1           sel   pc             next
      vecs[0]  = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20,        32'h0,        1'b1, 32'h100,       32'h120};
      vecs[1]  = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,        32'h0,        1'b0, 32'h100,       32'h104};
      vecs[2]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,        32'h0,        1'b1, 32'h104,       32'h114};
      vecs[3]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,        32'h0,        1'b0, 32'h114,       32'h118};
      vecs[4]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8,         32'h0,        1'b1, 32'h118,       32'h120};
      vecs[5]  = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,        32'h0,        1'b0, 32'h120,       32'h124};
      vecs[6]  = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40,        32'h0,        1'b0, 32'h124,       32'h128};
      vecs[7]  = '{1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,        32'h0,        1'b0, 32'h128,       32'h12C};
      vecs[8]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,       32'h0,        1'b1, 32'h12C,       32'h22C};
      vecs[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3,         32'h2001,     1'b1, 32'h22C,       32'h2004};
      vecs[10] = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10,        32'h3000,     1'b1, 32'h2004,      32'h3010};
      vecs[11] = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8,         32'h0,        1'b1, 32'h3010,      32'h3018};
      vecs[12] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h10,       1'b1, 32'h3018,      32'hFFFF_FFF0};
      vecs[13] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC,         32'h0,        1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC};
      vecs[14] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,        32'h0,        1'b0, 32'hFFFF_FFFC, 32'h0};
      vecs[15] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,        32'h0,        1'b1, 32'h0,         32'h20};
      for (int i = 0; i < 16; i++) runVec(vecs[i], $sformatf("v%0d", i));

      // BGEU taken with 3-cycle stall in EXEC
      doReset();
      funct = 3'b111; is_branch = 1; BrLT = 0; imm = 32'hFFFF_FFF8; stall = 1; imem_ready = 1;
      tick();
      imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_sel", {31'd0, PCSel}, 1);
         tick();
         chk("stall_pc", pc, 32'h100);
         chk("stall_req", {31'd0, imem_req}, 0);
      end
      stall = 0;
      tick();
      chk("bgeu_pc", pc, 32'hF8);
      chk("bgeu_req", {31'd0, imem_req}, 1);
`ifdef PC_CTRL_STATS_EN
      expBr = 1; expTk = 1;
`else
      expBr = 0; expTk = 0;
`endif
      chk("stall_br", br_cnt, expBr);
      chk("stall_tk", taken_cnt, expTk);

      // fetch wait: imem_ready low for 5 cycles
      clearIn();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_req", {31'd0, imem_req}, 1);
         chk("wait_pc", pc, 32'hF8);
      end

      // misaligned JAL target traps and holds until reset
      doReset();
      is_jal = 1; imm = 32'h2; imem_ready = 1;
      tick();
      chk("mis_sel", {31'd0, PCSel}, 1);
      tick();
      chk("trap_mis", {31'd0, misalign}, 1);
      chk("trap_pc", pc, 32'h100);
      chk("trap_req", {31'd0, imem_req}, 0);
      chk("trap_sel", {31'd0, PCSel}, 0);
      is_jal = 0; is_branch = 1; BrEq = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("trap_hold_mis", {31'd0, misalign}, 1);
         chk("trap_hold_pc", pc, 32'h100);
         chk("trap_hold_req", {31'd0, imem_req}, 0);
      end
      rst = 1;
      tick();
      chk("trap_rst_mis", {31'd0, misalign}, 0);

      // JALR with bit1 set in target also traps
      doReset();
      is_jalr = 1; rs1 = 32'h100; imm = 32'h2; imem_ready = 1;
      tick();
      tick();
      chk("jalr_mis", {31'd0, misalign}, 1);
      chk("jalr_mis_pc", pc, 32'h100);

      // statistics: 3 branches, 2 taken, plus a jump that is not counted
      doReset();
      v = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h100, 32'h108};
      runVec(v, "s0");
      v = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h108, 32'h10C};
      runVec(v, "s1");
      v = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h10C, 32'h114};
      runVec(v, "s2");
      v = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 32'h114, 32'h11C};
      runVec(v, "s3");
`ifdef PC_CTRL_STATS_EN
      expBr = 3; expTk = 2;
`else
      expBr = 0; expTk = 0;
`endif
      chk("stat_br", br_cnt, expBr);
      chk("stat_tk", taken_cnt, expTk);

      // reset mid-FETCH wins over imem_ready
      imem_ready = 1; rst = 1;
      tick();
      chk("midrst_pc", pc, 32'h100);
      chk("midrst_req", {31'd0, imem_req}, 0);
      chk("midrst_br", br_cnt, 0);
      chk("midrst_tk", taken_cnt, 0);
      tick();
      chk("midrst_hold_req", {31'd0, imem_req}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
